x_micro_seq_core: RTL and testbench

Parametrised micro-sequencer that executes a stored program of command/data words, replacing the fixed-width stub sequencer. Program memory is written over a simple write port while idle. After `i_start` the block fetches and executes instructions that drive a held data output, wait a cycle count, jump, loop and halt. It sits between the host register interface and the delay-line control datapath.

---
 rtl/x_micro_seq_core.sv | 172 +++++++++++++++++
 tb/tb_x_micro_seq_core.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_micro_seq_core.sv
// x_micro_seq_core: stored-program micro-sequencer executing OUT/WAIT/JUMP/LOOP/HALT words.
// Define X_MICRO_SEQ_LOOP_EN to build the single-level LOOP opcode (otherwise opcode 4 is a NOP).
module x_micro_seq_core #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  input  logic              i_wen,
  input  logic [CMD_W-1:0]  i_wcmd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_waddr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc
);

  localparam int unsigned WORD_W = DATA_W + CMD_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  localparam logic [CMD_W-1:0] OpOut  = CMD_W'(1);
  localparam logic [CMD_W-1:0] OpWait = CMD_W'(2);
  localparam logic [CMD_W-1:0] OpJump = CMD_W'(3);
  localparam logic [CMD_W-1:0] OpHalt = CMD_W'(15);
`ifdef X_MICRO_SEQ_LOOP_EN
  localparam logic [CMD_W-1:0] OpLoop = CMD_W'(4);
`endif

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  logic [1:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [CNT_W-1:0]  r_wcnt, w_wcnt_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_wr;
  logic [CMD_W-1:0]  w_cmd;
  logic [DATA_W-1:0] w_d;
  logic [CNT_W-1:0]  w_wait_n;

`ifdef X_MICRO_SEQ_LOOP_EN
  logic [CNT_W-1:0] r_loop_cnt, w_loop_cnt_nxt;
  logic             r_loop_act, w_loop_act_nxt;
  logic [CNT_W-1:0] w_loop_n;
  assign w_loop_n = w_d[ADDR_W+CNT_W-1:ADDR_W];
`endif

  assign w_wr     = i_wen && (r_state == StIdle);
  assign w_cmd    = r_rdata[CMD_W-1:0];
  assign w_d      = r_rdata[WORD_W-1:CMD_W];
  assign w_wait_n = w_d[CNT_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Read every cycle at pc; only the value captured on the FETCH edge is consumed.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[i_waddr] <= {i_wdata, i_wcmd};
    end
    r_rdata <= r_mem[r_pc];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wcnt_nxt  = r_wcnt;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
`ifdef X_MICRO_SEQ_LOOP_EN
    w_loop_cnt_nxt = r_loop_cnt;
    w_loop_act_nxt = r_loop_act;
`endif
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = StFetch;
          w_pc_nxt    = '0;
        end
      end
      StFetch: w_state_nxt = StExec;
      StExec: begin
        w_state_nxt = StFetch;
        w_pc_nxt    = w_pc_inc;
        case (w_cmd)
          OpOut: begin
            w_data_nxt  = w_d;
            w_valid_nxt = 1'b1;
          end
          OpWait: begin
            if (w_wait_n != '0) begin
              w_state_nxt = StWait;
              w_wcnt_nxt  = w_wait_n;
              w_pc_nxt    = r_pc;
            end
          end
          OpJump: w_pc_nxt = w_d[ADDR_W-1:0];
`ifdef X_MICRO_SEQ_LOOP_EN
          OpLoop: begin
            if (!r_loop_act && (w_loop_n != '0)) begin
              w_loop_act_nxt = 1'b1;
              w_loop_cnt_nxt = w_loop_n - CNT_W'(1);
              w_pc_nxt       = w_d[ADDR_W-1:0];
            end else if (r_loop_act && (r_loop_cnt != '0)) begin
              w_loop_cnt_nxt = r_loop_cnt - CNT_W'(1);
              w_pc_nxt       = w_d[ADDR_W-1:0];
            end else begin
              w_loop_act_nxt = 1'b0;
            end
          end
`endif
          OpHalt: begin
            w_state_nxt = StIdle;
            w_pc_nxt    = '0;
`ifdef X_MICRO_SEQ_LOOP_EN
            w_loop_cnt_nxt = '0;
            w_loop_act_nxt = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      StWait: begin
        if (r_wcnt == CNT_W'(1)) begin
          w_state_nxt = StFetch;
          w_pc_nxt    = w_pc_inc;
        end else begin
          w_wcnt_nxt = r_wcnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_wcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
`ifdef X_MICRO_SEQ_LOOP_EN
      r_loop_cnt <= '0;
      r_loop_act <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
`ifdef X_MICRO_SEQ_LOOP_EN
      r_loop_cnt <= w_loop_cnt_nxt;
      r_loop_act <= w_loop_act_nxt;
`endif
    end
  end

  assign o_busy  = (r_state != StIdle);
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_pc    = r_pc;

endmodule

// File: tb/tb_x_micro_seq_core.sv
// Bench for x_micro_seq_core: directed programs plus random programs against an
// instruction-level timing model; honours X_MICRO_SEQ_LOOP_EN.
module tb_x_micro_seq_core;

  localparam int unsigned DW = 36;
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned NW = 16;
  localparam int MAXC = 400;
`ifdef X_MICRO_SEQ_LOOP_EN
  localparam int LOOP_PULSES = 4;
`else
  localparam int LOOP_PULSES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          wen = 1'b0;
  logic [CW-1:0] wcmd = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] waddr = '0;
  logic          busy, valid;
  logic [DW-1:0] data;
  logic [AW-1:0] pc;

  x_micro_seq_core #(.DATA_W(DW), .CMD_W(CW), .ADDR_W(AW), .CNT_W(NW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .o_busy  (busy),
    .i_wen   (wen),
    .i_wcmd  (wcmd),
    .i_wdata (wdata),
    .i_waddr (waddr),
    .o_data  (data),
    .o_valid (valid),
    .o_pc    (pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [CW-1:0] p_cmd [8];
  logic [DW-1:0] p_dat [8];

  bit            e_valid [MAXC+4];
  logic [DW-1:0] e_data  [MAXC+4];
  bit            e_pchk  [MAXC+4];
  logic [AW-1:0] e_pc    [MAXC+4];
  int            e_halt;
  logic [DW-1:0] cur_out;
  int n_pulse, first_pulse, n_busy;
  int fp0, tries;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [CW-1:0] c, input logic [DW-1:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = AW'(a); wcmd = c; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < 8; i++) wr(i, p_cmd[i], p_dat[i]);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 8; i++) begin p_cmd[i] = CW'(15); p_dat[i] = '0; end
  endtask

  // Walks the program instruction by instruction: every instruction costs 2 cycles
  // (WAIT n costs 2+n); OUT becomes visible 2 cycles after the instruction starts.
  task automatic model();
    int s = 0;
    int n;
    logic [AW-1:0] mpc = '0;
    bit act = 0;
    int lc = 0;
    logic [CW-1:0] c;
    logic [DW-1:0] d, held;
    for (int i = 0; i < MAXC + 4; i++) begin
      e_valid[i] = 0; e_pchk[i] = 0; e_pc[i] = '0; e_data[i] = '0;
    end
    e_halt = -1;
    while (s < MAXC && e_halt < 0) begin
      c = p_cmd[mpc];
      d = p_dat[mpc];
      e_pchk[s+1] = 1; e_pc[s+1] = mpc;
      case (c)
        CW'(1): begin e_valid[s+2] = 1; e_data[s+2] = d; s += 2; mpc++; end
        CW'(2): begin
          n = int'(d[NW-1:0]);
          for (int w = 0; w < n && s + 2 + w < MAXC + 4; w++) begin
            e_pchk[s+2+w] = 1; e_pc[s+2+w] = mpc;
          end
          s += 2 + n; mpc++;
        end
        CW'(3): begin s += 2; mpc = d[AW-1:0]; end
`ifdef X_MICRO_SEQ_LOOP_EN
        CW'(4): begin
          n = int'(d[AW+NW-1:AW]);
          s += 2;
          if (!act && n > 0) begin act = 1; lc = n - 1; mpc = d[AW-1:0]; end
          else if (act && lc > 0) begin lc--; mpc = d[AW-1:0]; end
          else begin act = 0; mpc++; end
        end
`endif
        CW'(15): e_halt = s + 2;
        default: begin s += 2; mpc++; end
      endcase
    end
    held = cur_out;
    for (int i = 0; i < MAXC + 4; i++) begin
      if (e_valid[i]) held = e_data[i];
      e_data[i] = held;
    end
  endtask

  // Start the loaded program and compare every cycle until the model's halt point.
  task automatic run(input string tag, input bit disturb, input bit same_wr);
    n_pulse = 0; first_pulse = -1; n_busy = 0;
    model();
    @(negedge clk);
    start = 1'b1;
    if (same_wr) begin wen = 1'b1; waddr = '0; wcmd = p_cmd[0]; wdata = p_dat[0]; end
    for (int c = 0; c <= e_halt; c++) begin
      @(negedge clk);
      start = 1'b0; wen = 1'b0;
      if (disturb && c == 2) begin
        start = 1'b1; wen = 1'b1; waddr = AW'(1); wcmd = CW'(15); wdata = '1;
      end
      chk({tag, "/busy"}, 64'(busy), 64'(c < e_halt));
      chk({tag, "/valid"}, 64'(valid), 64'(e_valid[c]));
      chk({tag, "/data"}, 64'(data), 64'(e_data[c]));
      if (e_pchk[c]) chk({tag, "/pc"}, 64'(pc), 64'(e_pc[c]));
      if (valid) begin
        if (first_pulse < 0) first_pulse = c;
        n_pulse++;
      end
      if (busy) n_busy++;
    end
    if (e_halt >= 0) cur_out = e_data[e_halt];
  endtask

  task automatic gen();
    logic [63:0] rr;
    for (int i = 0; i < 8; i++) begin
      rr = {$urandom, $urandom};
      p_dat[i] = rr[DW-1:0];
      case ($urandom_range(0, 9))
        0:       p_cmd[i] = CW'(0);
        1, 2, 9: p_cmd[i] = CW'(1);
        3: begin p_cmd[i] = CW'(2); p_dat[i][NW-1:0] = NW'($urandom_range(0, 4)); end
        4:       p_cmd[i] = CW'(3);
        5, 6: begin p_cmd[i] = CW'(4); p_dat[i][AW+NW-1:AW] = NW'($urandom_range(0, 3)); end
        7:       p_cmd[i] = CW'($urandom_range(5, 14));
        default: p_cmd[i] = CW'(15);
      endcase
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle behaviour
    #1 rst_n = 1'b0;
    #3;
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/data", 64'(data), 64'd0);
    chk("rst/pc", 64'(pc), 64'd0);
    chk("rst/valid", 64'(valid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle/busy", 64'(busy), 64'd0);
    chk("idle/pc", 64'(pc), 64'd0);
    wr(3, CW'(1), DW'(5));
    repeat (2) @(negedge clk);
    chk("idlewr/busy", 64'(busy), 64'd0);
    chk("idlewr/valid", 64'(valid), 64'd0);
    cur_out = '0;

    // OUT then HALT
    fill_halt();
    p_cmd[0] = CW'(1); p_dat[0] = 36'h123456789;
    load();
    run("outhalt", 0, 0);
    chk("outhalt/pulses", 64'(n_pulse), 64'd1);
    chk("outhalt/lat", 64'(first_pulse), 64'd2);
    chk("outhalt/busycyc", 64'(n_busy), 64'd4);

    // WAIT 0 versus WAIT 5
    fill_halt();
    p_cmd[0] = CW'(2); p_dat[0] = '0;
    p_cmd[1] = CW'(1); p_dat[1] = DW'(1);
    load();
    run("wait0", 0, 0);
    fp0 = first_pulse;
    p_dat[0] = DW'(5);
    wr(0, p_cmd[0], p_dat[0]);
    run("wait5", 0, 0);
    chk("wait/delta", 64'(first_pulse - fp0), 64'd5);

    // LOOP target 0, n=3
    fill_halt();
    p_cmd[0] = CW'(1); p_dat[0] = DW'(7);
    p_cmd[1] = CW'(4); p_dat[1] = '0; p_dat[1][AW+NW-1:AW] = NW'(3);
    load();
    run("loop", 0, 0);
    chk("loop/pulses", 64'(n_pulse), 64'(LOOP_PULSES));

    // Writes and start while busy are ignored
    fill_halt();
    p_cmd[0] = CW'(1); p_dat[0] = DW'('hA);
    p_cmd[1] = CW'(2); p_dat[1] = DW'(3);
    p_cmd[2] = CW'(1); p_dat[2] = DW'('hB);
    load();
    run("busyprot", 1, 0);
    chk("busyprot/pulses", 64'(n_pulse), 64'd2);
    run("busyprot2", 0, 0);
    chk("busyprot2/pulses", 64'(n_pulse), 64'd2);

    // Start and write address 0 in the same idle cycle
    fill_halt();
    p_cmd[0] = CW'(1); p_dat[0] = DW'('h55);
    load();
    wr(0, CW'(15), '0);
    run("samewr", 0, 1);
    chk("samewr/pulses", 64'(n_pulse), 64'd1);

    // Random programs
    for (int k = 0; k < 20; k++) begin
      tries = 0;
      do begin gen(); model(); tries++; end while (e_halt < 0 && tries < 200);
      if (e_halt < 0) fill_halt();
      load();
      run("rnd", 0, 0);
    end

    // JUMP with pc wrap, reset mid-run, RAM preserved
    fill_halt();
    p_cmd[0] = CW'(3); p_dat[0] = DW'(7);
    p_cmd[7] = CW'(1); p_dat[7] = DW'(9);
    load();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (c % 2 == 1) chk("jw/pc", 64'(pc), (c % 4 == 1) ? 64'd0 : 64'd7);
        if (c == 4) begin
          chk("jw/valid", 64'(valid), 64'd1);
          chk("jw/data", 64'(data), 64'd9);
        end
      end
      chk("jw/busyrun", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("jwrst/busy", 64'(busy), 64'd0);
      chk("jwrst/pc", 64'(pc), 64'd0);
      chk("jwrst/data", 64'(data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    cur_out = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
